// File: rtl/sat_monitor_pkg.sv
// Shared saturation constants and the power-of-two clamp window helper,
// reused by sat14 users and the register map.
package sat_monitor_pkg;

    localparam int SAT_RES  = 14;
    localparam int SAT_LIMW = 4;
    localparam int SAT_WINW = 32;

    typedef struct packed {
        logic [SAT_WINW-1:0] mask;
        logic [SAT_WINW-1:0] max;
        logic [SAT_WINW-1:0] min;
    } sat_win_t;

    // Callers truncate the fields to their sample width; min equals the mask.
    function automatic sat_win_t clamp_window(input logic [SAT_WINW-1:0] lim);
        sat_win_t w;
        w.mask = {SAT_WINW{1'b1}} << lim;
        w.max  = ~w.mask;
        w.min  = w.mask;
        return w;
    endfunction

endpackage

// File: rtl/sat_episode_cnt.sv
// One clamp polarity: registered flag, rising-edge episode counter and sticky flag.
module sat_episode_cnt #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            hit,
    output logic            sat,
    output logic            stk,
    output logic [CNTW-1:0] cnt
);

    logic rise;

    // sat doubles as the edge-detect history, so clr leaves it untouched.
    assign rise = hit & ~sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat <= 1'b0;
            stk <= 1'b0;
            cnt <= '0;
        end else begin
            sat <= hit;
            if (clr) begin
                stk <= 1'b0;
                cnt <= '0;
            end else begin
                stk <= stk | hit;
                if (rise && (cnt != {CNTW{1'b1}}))
                    cnt <= cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/sat_monitor.sv
// Registered power-of-two saturation stage with sticky flags, episode
// counters and a stretched activity indicator.
module sat_monitor
    import sat_monitor_pkg::*;
#(
    parameter int RES   = SAT_RES,
    parameter int LIMW  = SAT_LIMW,
    parameter int CNTW  = 16,
    parameter int HOLDW = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [RES-1:0]  in,
    input  logic        [LIMW-1:0] lim,
    input  logic        [HOLDW-1:0] hold,
    input  logic                   clr,
    output logic signed [RES-1:0]  out,
    output logic                   sat_pos,
    output logic                   sat_neg,
    output logic                   stk_pos,
    output logic                   stk_neg,
    output logic        [CNTW-1:0] cnt_pos,
    output logic        [CNTW-1:0] cnt_neg,
    output logic                   active
);

    logic [LIMW-1:0]       lim_eff;
    sat_win_t              win;
    logic signed [RES-1:0] max_v;
    logic signed [RES-1:0] min_v;
    logic                  pos_hit;
    logic                  neg_hit;
    logic [HOLDW-1:0]      timer;

    // Out-of-range exponents fall back to the widest legal window.
    assign lim_eff = (32'(lim) >= RES) ? LIMW'(RES - 1) : lim;
    assign win     = clamp_window(SAT_WINW'(lim_eff));
    assign max_v   = win.max[RES-1:0];
    assign min_v   = win.min[RES-1:0];

    assign pos_hit = ~in[RES-1] && ((in >> lim_eff) != '0);
    assign neg_hit =  in[RES-1] && (((~in) >> lim_eff) != '0);

    always_ff @(posedge clk) begin
        if (rst)
            out <= '0;
        else if (pos_hit)
            out <= max_v;
        else if (neg_hit)
            out <= min_v;
        else
            out <= in;
    end

    sat_episode_cnt #(.CNTW(CNTW)) u_pos (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .hit (pos_hit),
        .sat (sat_pos),
        .stk (stk_pos),
        .cnt (cnt_pos)
    );

    sat_episode_cnt #(.CNTW(CNTW)) u_neg (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .hit (neg_hit),
        .sat (sat_neg),
        .stk (stk_neg),
        .cnt (cnt_neg)
    );

    // hold is captured only while a clamp is visible on the outputs.
    always_ff @(posedge clk) begin
        if (rst)
            timer <= '0;
        else if (sat_pos | sat_neg)
            timer <= hold;
        else if (timer != '0)
            timer <= timer - HOLDW'(1);
    end

    assign active = sat_pos | sat_neg | (timer != '0);

endmodule

// File: tb/tb_sat_monitor.sv
// Directed bench for sat_monitor: clamp values, flags, episode counting,
// clr priority, hold stretching and reset, with a CNTW=4 copy for counter saturation.
module tb_sat_monitor;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [13:0] in;
    logic        [3:0]  lim;
    logic        [23:0] hold;
    logic               clr;

    logic signed [13:0] out, out4;
    logic               sat_pos, sat_neg, stk_pos, stk_neg, active;
    logic               sat_pos4, sat_neg4, stk_pos4, stk_neg4, active4;
    logic        [15:0] cnt_pos, cnt_neg;
    logic        [3:0]  cnt_pos4, cnt_neg4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sat_monitor dut (
        .clk(clk), .rst(rst), .in(in), .lim(lim), .hold(hold), .clr(clr),
        .out(out), .sat_pos(sat_pos), .sat_neg(sat_neg),
        .stk_pos(stk_pos), .stk_neg(stk_neg),
        .cnt_pos(cnt_pos), .cnt_neg(cnt_neg), .active(active)
    );

    sat_monitor #(.CNTW(4)) dut4 (
        .clk(clk), .rst(rst), .in(in), .lim(lim), .hold(hold), .clr(clr),
        .out(out4), .sat_pos(sat_pos4), .sat_neg(sat_neg4),
        .stk_pos(stk_pos4), .stk_neg(stk_neg4),
        .cnt_pos(cnt_pos4), .cnt_neg(cnt_neg4), .active(active4)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs are sampled on the next rising edge; outputs are read 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string tag, input int o, input int sp, input int sn,
                         input int cp, input int cn);
        chk({tag, ".out"}, int'(out), o);
        chk({tag, ".sat_pos"}, int'(sat_pos), sp);
        chk({tag, ".sat_neg"}, int'(sat_neg), sn);
        chk({tag, ".cnt_pos"}, int'(cnt_pos), cp);
        chk({tag, ".cnt_neg"}, int'(cnt_neg), cn);
    endtask

    initial begin
        rst = 1'b1; in = 14'sd100; lim = 4'd3; hold = 24'd0; clr = 1'b0;
        #1;
        step();
        flags("rst", 0, 0, 0, 0, 0);
        chk("rst.stk_pos", int'(stk_pos), 0);
        chk("rst.active", int'(active), 0);

        rst = 1'b0;
        step();
        flags("lim3_p100", 7, 1, 0, 1, 0);
        chk("lim3_p100.stk_pos", int'(stk_pos), 1);
        chk("lim3_p100.active", int'(active), 1);
        in = -14'sd100; step();
        flags("lim3_m100", -8, 0, 1, 1, 1);
        chk("lim3_m100.stk_neg", int'(stk_neg), 1);
        in = 14'sd5; step();
        flags("lim3_p5", 5, 0, 0, 1, 1);
        chk("lim3_p5.active", int'(active), 0);
        chk("lim3_p5.stk_pos", int'(stk_pos), 1);

        lim = 4'd0;
        in = 14'sd0;  step(); flags("lim0_0", 0, 0, 0, 1, 1);
        in = 14'sd5;  step(); flags("lim0_5", 0, 1, 0, 2, 1);
        in = -14'sd1; step(); flags("lim0_m1", -1, 0, 0, 2, 1);
        in = -14'sd2; step(); flags("lim0_m2", -1, 0, 1, 2, 2);

        lim = 4'd13;
        in = 14'sd8191;  step(); flags("lim13_max", 8191, 0, 0, 2, 2);
        in = -14'sd8192; step(); flags("lim13_min", -8192, 0, 0, 2, 2);
        lim = 4'd12; in = 14'sd4096; step(); flags("lim12_4096", 4095, 1, 0, 3, 2);
        lim = 4'd15; in = 14'sd8191;  step(); flags("lim15_max", 8191, 0, 0, 3, 2);
        in = -14'sd8192; step(); flags("lim15_min", -8192, 0, 0, 3, 2);

        lim = 4'd3; in = 14'sd0; clr = 1'b1; step(); clr = 1'b0;
        flags("clr_idle", 0, 0, 0, 0, 0);
        chk("clr_idle.stk_neg", int'(stk_neg), 0);
        in = 14'sd100;
        for (int i = 0; i < 50; i++) step();
        in = 14'sd0; step();
        in = 14'sd100;
        for (int i = 0; i < 10; i++) step();
        chk("ep2.cnt_pos", int'(cnt_pos), 2);
        chk("ep2.cnt_pos4", int'(cnt_pos4), 2);
        for (int i = 0; i < 20; i++) begin
            in = 14'sd0;   step();
            in = 14'sd100; step();
        end
        in = 14'sd0; step();
        chk("ep22.cnt_pos", int'(cnt_pos), 22);
        chk("ep22.cnt_pos4_sat", int'(cnt_pos4), 15);

        in = 14'sd100; step();
        chk("held.cnt_pos", int'(cnt_pos), 23);
        clr = 1'b1; step(); clr = 1'b0;
        flags("clr_held", 7, 1, 0, 0, 0);
        chk("clr_held.stk_pos", int'(stk_pos), 0);
        step();
        chk("after_clr.stk_pos", int'(stk_pos), 1);
        chk("after_clr.cnt_pos", int'(cnt_pos), 0);
        in = 14'sd0; step();
        in = 14'sd100; clr = 1'b1; step(); clr = 1'b0;
        chk("clr_rise.stk_pos", int'(stk_pos), 0);
        chk("clr_rise.cnt_pos", int'(cnt_pos), 0);
        chk("clr_rise.sat_pos", int'(sat_pos), 1);

        in = 14'sd0; step();
        chk("hold0.active", int'(active), 0);
        hold = 24'd5; in = 14'sd100; step();
        chk("hold5.clamp_active", int'(active), 1);
        in = 14'sd0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("hold5.t%0d", i), int'(active), (i < 5) ? 1 : 0);
        end

        in = 14'sd100; step();
        in = 14'sd0; step();
        chk("midhold.active", int'(active), 1);
        in = 14'sd100; rst = 1'b1; step();
        flags("rst_mid", 0, 0, 0, 0, 0);
        chk("rst_mid.active", int'(active), 0);
        chk("rst_mid.stk_pos", int'(stk_pos), 0);
        rst = 1'b0; step();
        flags("post_rst", 7, 1, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
